// File: rtl/pointwise_conv_scheduler_if.sv
// Buffer and engine side of the pointwise conv scheduler.
// master = scheduler, slave = buffers plus engine.
interface pointwise_conv_scheduler_if #(
   parameter int N            = 16,
   parameter int IN_CHANNELS  = 40,
   parameter int OUT_CHANNELS = 48,
   parameter int FEATURE_SIZE = 14
);
   localparam int PIX = FEATURE_SIZE * FEATURE_SIZE;
   localparam int IAW = $clog2(PIX * IN_CHANNELS);
   localparam int OAW = $clog2(PIX * OUT_CHANNELS);
   localparam int CW  = $clog2(IN_CHANNELS);
   localparam int BW  = $clog2(OUT_CHANNELS);

   logic           in_rd_en;
   logic [IAW-1:0] in_rd_addr;
   logic [N-1:0]   in_rd_data;
   logic [N-1:0]   pe_data;
   logic [CW-1:0]  pe_channel;
   logic           pe_valid;
   logic [N-1:0]   pe_data_out;
   logic [BW-1:0]  pe_channel_out;
   logic           pe_valid_out;
   logic           out_wr_en;
   logic [OAW-1:0] out_wr_addr;
   logic [N-1:0]   out_wr_data;

   modport master (
      output in_rd_en, in_rd_addr,
      input  in_rd_data,
      output pe_data, pe_channel, pe_valid,
      input  pe_data_out, pe_channel_out, pe_valid_out,
      output out_wr_en, out_wr_addr, out_wr_data
   );

   modport slave (
      input  in_rd_en, in_rd_addr,
      output in_rd_data,
      input  pe_data, pe_channel, pe_valid,
      output pe_data_out, pe_channel_out, pe_valid_out,
      input  out_wr_en, out_wr_addr, out_wr_data
   );
endinterface

// File: rtl/pointwise_conv_scheduler.sv
// Walks a feature map pixel by pixel: feeds the pointwise engine,
// drains its results into the output buffer, flags protocol errors.
module pointwise_conv_scheduler #(
   parameter int N            = 16,
   parameter int IN_CHANNELS  = 40,
   parameter int OUT_CHANNELS = 48,
   parameter int FEATURE_SIZE = 14,
   parameter int TIMEOUT      = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic start,
   output logic busy,
   output logic done,
   output logic err_channel,
   output logic err_unexpected,
   output logic err_timeout,
   pointwise_conv_scheduler_if.master bus
);
   localparam int PIX = FEATURE_SIZE * FEATURE_SIZE;
   localparam int PW  = $clog2(PIX);
   localparam int CW  = $clog2(IN_CHANNELS);
   localparam int BW  = $clog2(OUT_CHANNELS);
   localparam int IAW = $clog2(PIX * IN_CHANNELS);
   localparam int OAW = $clog2(PIX * OUT_CHANNELS);
   localparam int TW  = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, FEED, DRAIN, NEXT, FINISH
   } state_t;

   state_t state, nxt;

   logic [PW-1:0]  pixel;
   logic [CW-1:0]  ch;
   logic [BW-1:0]  beat;
   logic [TW-1:0]  wdog;
   logic           pv_q;
   logic [CW-1:0]  pc_q;
   logic           wr_q;
   logic [OAW-1:0] wr_addr;
   logic [N-1:0]   wr_data;

   logic last_ch, last_beat, last_pix, wd_exp, beat_in;

   assign last_ch   = ch == CW'(IN_CHANNELS - 1);
   assign last_beat = beat == BW'(OUT_CHANNELS - 1);
   assign last_pix  = pixel == PW'(PIX - 1);
   assign wd_exp    = wdog == TW'(TIMEOUT - 1);
   assign beat_in   = bus.pe_valid_out && state == DRAIN;

   assign bus.in_rd_addr  = IAW'(pixel) * IAW'(IN_CHANNELS) + IAW'(ch);
   // Read data arrives one cycle late, so the feed stage is a flag plus
   // the captured channel; data passes straight from the buffer.
   assign bus.pe_valid    = pv_q & en;
   assign bus.pe_channel  = pc_q;
   assign bus.pe_data     = pv_q ? bus.in_rd_data : '0;
   assign bus.out_wr_en   = wr_q & en;
   assign bus.out_wr_addr = wr_addr;
   assign bus.out_wr_data = wr_data;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else if (en)
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:   if (start) nxt = FEED;
         FEED:   if (last_ch) nxt = DRAIN;
         DRAIN: begin
            if (beat_in && last_beat)
               nxt = NEXT;
            else if (!bus.pe_valid_out && wd_exp)
               nxt = FINISH;
         end
         NEXT:   nxt = last_pix ? FINISH : FEED;
         FINISH: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy         = 1'b0;
      done         = 1'b0;
      bus.in_rd_en = 1'b0;
      unique case (state)
         FEED: begin
            busy         = 1'b1;
            bus.in_rd_en = en;
         end
         DRAIN, NEXT: busy = 1'b1;
         FINISH:      done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pixel          <= '0;
         ch             <= '0;
         beat           <= '0;
         wdog           <= '0;
         pv_q           <= 1'b0;
         pc_q           <= '0;
         wr_q           <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
         err_channel    <= 1'b0;
         err_unexpected <= 1'b0;
         err_timeout    <= 1'b0;
      end else if (en) begin
         pv_q <= state == FEED;
         wr_q <= beat_in;
         if (state == FEED)
            pc_q <= ch;
         if (bus.pe_valid_out && state != DRAIN)
            err_unexpected <= 1'b1;
         if (state != DRAIN)
            wdog <= '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  pixel          <= '0;
                  ch             <= '0;
                  beat           <= '0;
                  err_channel    <= 1'b0;
                  err_unexpected <= 1'b0;
                  err_timeout    <= 1'b0;
               end
            end
            FEED: if (!last_ch) ch <= ch + 1'b1;
            DRAIN: begin
               if (beat_in) begin
                  // A wrong channel is flagged but still lands at the beat slot.
                  wr_addr <= OAW'(pixel) * OAW'(OUT_CHANNELS) + OAW'(beat);
                  wr_data <= bus.pe_data_out;
                  wdog    <= '0;
                  if (bus.pe_channel_out != beat)
                     err_channel <= 1'b1;
                  if (!last_beat)
                     beat <= beat + 1'b1;
               end else if (wd_exp) begin
                  err_timeout <= 1'b1;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            NEXT: begin
               ch   <= '0;
               beat <= '0;
               if (!last_pix)
                  pixel <= pixel + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/pointwise_conv_scheduler.md
# pointwise_conv_scheduler

Sequencer that drives the pointwise convolution engine across a full feature map. For each pixel it:
- streams all `IN_CHANNELS` activations from the input feature buffer into the engine's `data_in`/`channel_in`/`valid_in` port;
- collects the `OUT_CHANNELS` results from the engine's `valid_out` stream and writes them to the output feature buffer;
- moves on to the next pixel.

It sits between the feature-map buffers and the pointwise engine inside a MobileNetV3 bottleneck and reports start/busy/done plus sticky protocol-error flags to the layer controller.

## Interface
- `N`, 16, activation/result width (Q8.8)
- `IN_CHANNELS`, 40, activations per pixel
- `OUT_CHANNELS`, 48, results per pixel
- `FEATURE_SIZE`, 14, feature map is `FEATURE_SIZE`×`FEATURE_SIZE` pixels
- `TIMEOUT`, 1024, maximum cycles without a result beat while draining
- `clk` in 1: single clock; everything is on its rising edge
- `rst` in 1: synchronous, active-high reset
- `en` in 1: global enable; when low, all registers hold
- `start` in 1: begin a layer pass; sampled only in IDLE
- `busy` out 1: high from the cycle after `start` is accepted until FINISH
- `done` out 1: one-cycle pulse in FINISH
- `in_rd_en` out 1: input buffer read strobe
- `in_rd_addr` out clog2(FS²·IN): equals pixel·IN_CHANNELS + ch
- `in_rd_data` in N: valid one cycle after `in_rd_en`; held until the next read
- `pe_data` out N: engine `data_in`
- `pe_channel` out clog2(IN): engine `channel_in`
- `pe_valid` out 1: engine `valid_in`
- `pe_data_out` in N: engine result
- `pe_channel_out` in clog2(OUT): engine result channel
- `pe_valid_out` in 1: engine result strobe
- `out_wr_en` out 1: output buffer write strobe
- `out_wr_addr` out clog2(FS²·OUT): equals pixel·OUT_CHANNELS + beat
- `out_wr_data` out N: result written to the output buffer
- `err_channel` out 1: sticky; a result's channel did not match the expected beat index
- `err_unexpected` out 1: sticky; `pe_valid_out` arrived outside DRAIN
- `err_timeout` out 1: sticky; DRAIN watchdog expired

## Operation
- **States:** IDLE, FEED, DRAIN, NEXT, FINISH.
- **IDLE:**
  - on `start`: clear pixel, ch, beat and all error flags; go to FEED.
  - `start` outside IDLE is ignored.
- **FEED:**
  - each cycle: `in_rd_en`=1, `in_rd_addr`=pixel·IN+ch, then ch++.
  - after the ch=IN−1 read, go to DRAIN.
- **Engine feed stage:**
  - one cycle after each read: `pe_valid`=1, `pe_data`=`in_rd_data`, `pe_channel`=the ch of that read.
  - the last `pe_valid` therefore falls in the first DRAIN cycle.
- **DRAIN:**
  - each `pe_valid_out` writes `pe_data_out` to address pixel·OUT+beat, then beat++.
  - if `pe_channel_out` ≠ beat: set `err_channel`; the data is still written at the expected address.
  - after beat OUT−1 is accepted, go to NEXT.
- **Watchdog:**
  - counts DRAIN cycles without `pe_valid_out`; reset on every beat.
  - on reaching `TIMEOUT`: set `err_timeout` and go to FINISH, skipping the remaining pixels.
- **NEXT:**
  - clear ch and beat.
  - if pixel = FS²−1 go to FINISH; otherwise pixel++ and go to FEED.
- **FINISH:** `done`=1 for one cycle, `busy`=0, then IDLE.
- **`pe_valid_out` in any state other than DRAIN:** ignored (no write); sets `err_unexpected`.
- **`en`=0:**
  - state, counters, watchdog and all output registers hold.
  - strobes (`in_rd_en`, `pe_valid`, `out_wr_en`) are forced to 0 that cycle and reissue unchanged when `en` returns.
  - the engine is stalled by the same `en`, so no results are lost.
- **`rst`:** from any state, including mid-pass, go to IDLE next edge with all counters cleared and all outputs 0.

## Timing
- **Reset values:** every output is 0; `pe_data`, `pe_channel`, `out_wr_addr` and `out_wr_data` are also 0.
- **Read latency:** 1 cycle, so `pe_*` lags `in_rd_*` by exactly one cycle.
- **Write path:** `out_wr_*` is registered and lands 1 cycle after the `pe_valid_out` beat; the final write of a pixel lands in NEXT.
- **Per-pixel cycles:** IN (FEED) + D (DRAIN, from entry to the last beat) + 1 (NEXT).
- **Whole pass:** `start` → `busy` in 1 cycle; `done` pulses one cycle after the last NEXT.
- **Counters:**
  - all counters are unsigned, sized by `$clog2`.
  - pixel never exceeds FS²−1, ch never exceeds IN−1, beat never exceeds OUT−1; there is no wrap-around.
- **`start` and `rst` in the same cycle:** `rst` wins.

## Test plan
- **Reset:** assert `rst` for 3 cycles with random inputs → all outputs 0, `busy`=0.
- **Full run** (FS=2, IN=4, OUT=3; engine model returns 3 beats, channels 0..2, 5 cycles after its last input):
  - `in_rd_addr` sequence is 0..15, each pixel's reads contiguous.
  - `pe_channel` repeats 0..3, lagging `in_rd_addr` by one cycle.
  - `out_wr_addr` is 0..11.
  - exactly one `done` pulse; no error flags set.
- **Stall:** drop `en` for 3 cycles at ch=2 of pixel 1 → no duplicated or skipped read address; the `pe_*` sequence is identical to the unstalled run.
- **Timeout** (TIMEOUT=16): engine never responds for pixel 0 → `err_timeout`=1 on the 16th silent cycle, `done` pulses, `busy` falls, no further reads.
- **Protocol errors:**
  - engine returns channel 2 on beat 0 → `err_channel`=1 and data written at address 0.
  - a `pe_valid_out` during FEED → `err_unexpected`=1 and no write.
  - both flags clear on the next `start`.
- **Control edges:**
  - `start` pulsed while `busy` → ignored.
  - `rst` asserted mid-DRAIN → all outputs 0 the next cycle; a fresh `start` completes a clean run.
